k15_op_resp: RTL and testbench

//  Responder at the far end of the k15_op req/ack channel. Consumes 24-bit ops from the k15_op

---
 rtl/k15_pkg.sv | 38 +++
 rtl/k15_rsp_fifo.sv | 61 ++++++
 rtl/k15_op_resp.sv | 136 +++++++++++++
 tb/tb_k15_op_resp.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/k15_pkg.sv
// Shared definitions for the k15_op responder: opcodes, status codes,
// op/response field positions and the FSM state type.
package k15_pkg;

    // Opcodes carried in op[23:20]
    localparam logic [3:0] K15_OP_NOP = 4'h0;
    localparam logic [3:0] K15_OP_WR  = 4'h1;
    localparam logic [3:0] K15_OP_RD  = 4'h2;
    localparam logic [3:0] K15_OP_ADD = 4'h3;
    localparam logic [3:0] K15_OP_CLR = 4'h4;

    // Status echoed for any opcode the responder does not implement
    localparam logic [3:0] K15_ST_ERR = 4'hF;

    // Field positions shared by ops and responses
    localparam int K15_OPC_MSB  = 23;
    localparam int K15_OPC_LSB  = 20;
    localparam int K15_ADDR_MSB = 19;
    localparam int K15_ADDR_LSB = 16;
    localparam int K15_DATA_MSB = 15;
    localparam int K15_DATA_LSB = 0;

    // Data word returned once a CLR has wiped the whole register file
    localparam logic [15:0] K15_CLR_DONE = 16'h0010;

    typedef enum logic {
        K15_IDLE,
        K15_CLR_RUN
    } k15_state_e;

    // Packs a response word in the common {status, addr, data} layout
    function automatic logic [23:0] k15_rsp(input logic [3:0]  opc,
                                            input logic [3:0]  addr,
                                            input logic [15:0] data);
        return {opc, addr, data};
    endfunction

endpackage

// File: rtl/k15_rsp_fifo.sv
// Registered response buffer. Push side is a simple strobe from the
// responder; pop side is a req/ack initiator port whose data is the head
// entry and stays stable until it is acknowledged.
module k15_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 24,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    output logic [W-1:0]  rsp_dat,
    output logic          rsp_req,
    input  logic          rsp_ack,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [W-1:0]  mem [2**PW];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign rsp_req = (count != '0);
    assign rsp_dat = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign pop     = rsp_req & rsp_ack;

    // Storage, pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the storage is reset too, because the head entry drives the
            // output port directly and must read as zero out of reset.
            for (int i = 0; i < 2**PW; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values regardless of statement order.
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/k15_op_resp.sv
// Far-end responder of the k15_op channel: accepts ops, executes them
// against a 16x16 register file and queues one response per non-NOP op.
// CLR runs as a 16-cycle sweep with the op port closed.
module k15_op_resp
    import k15_pkg::*;
#(
    parameter int RF_AW     = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] t_k15_op_dat,
    input  logic        t_k15_op_req,
    output logic        t_k15_op_ack,
    output logic [23:0] i_k15_rsp_dat,
    output logic        i_k15_rsp_req,
    input  logic        i_k15_rsp_ack
);

    localparam int RSP_CW = $clog2(RSP_DEPTH + 1);

    logic [15:0]      rf [2**RF_AW];
    k15_state_e       state;
    logic [RF_AW-1:0] clr_idx;
    logic             ack_en;

    logic [3:0]       op_opc;
    logic [RF_AW-1:0] op_addr;
    logic [15:0]      op_data;
    logic [15:0]      add_sum;
    logic             op_fire;
    logic             clr_done;

    logic             push;
    logic [23:0]      push_dat;
    logic             rf_we;
    logic [15:0]      rf_wdat;
    logic [RSP_CW-1:0] rsp_count;
    logic             rsp_full;

    assign op_opc  = t_k15_op_dat[K15_OPC_MSB:K15_OPC_LSB];
    assign op_addr = t_k15_op_dat[K15_ADDR_MSB:K15_ADDR_LSB];
    assign op_data = t_k15_op_dat[K15_DATA_MSB:K15_DATA_LSB];
    assign add_sum = rf[op_addr] + op_data;

    // Ack depends only on registers; ack_en keeps it low until the first
    // edge after reset release. A pop this cycle does not reopen the port.
    assign t_k15_op_ack = ack_en & (state == K15_IDLE) & ~rsp_full;
    assign op_fire      = t_k15_op_req & t_k15_op_ack;
    assign clr_done     = (state == K15_CLR_RUN) && (clr_idx == '1);

    // Decode the accepted op (or CLR completion) into rf write and response push
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        push     = 1'b0;
        push_dat = '0;
        rf_we    = 1'b0;
        rf_wdat  = '0;
        if (clr_done) begin
            push     = 1'b1;
            push_dat = k15_rsp(K15_OP_CLR, 4'h0, K15_CLR_DONE);
        end else if (op_fire) begin
            case (op_opc)
                K15_OP_NOP: ;
                K15_OP_CLR: ;
                K15_OP_WR: begin
                    rf_we    = 1'b1;
                    rf_wdat  = op_data;
                    push     = 1'b1;
                    push_dat = k15_rsp(K15_OP_WR, op_addr, op_data);
                end
                K15_OP_RD: begin
                    push     = 1'b1;
                    push_dat = k15_rsp(K15_OP_RD, op_addr, rf[op_addr]);
                end
                K15_OP_ADD: begin
                    rf_we    = 1'b1;
                    rf_wdat  = add_sum;
                    push     = 1'b1;
                    push_dat = k15_rsp(K15_OP_ADD, op_addr, add_sum);
                end
                default: begin
                    push     = 1'b1;
                    push_dat = k15_rsp(K15_ST_ERR, op_addr, op_data);
                end
            endcase
        end
    end

    // FSM, clear sweep and register-file updates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= K15_IDLE;
            clr_idx <= '0;
            ack_en  <= 1'b0;
            for (int i = 0; i < 2**RF_AW; i++) rf[i] <= '0;
        end else begin
            ack_en <= 1'b1;
            if (rf_we) rf[op_addr] <= rf_wdat;
            case (state)
                K15_IDLE: begin
                    if (op_fire && (op_opc == K15_OP_CLR)) begin
                        state   <= K15_CLR_RUN;
                        clr_idx <= '0;
                    end
                end
                K15_CLR_RUN: begin
                    rf[clr_idx] <= '0;
                    clr_idx     <= clr_idx + 1'b1;
                    if (clr_done) state <= K15_IDLE;
                end
                default: state <= K15_IDLE;
            endcase
        end
    end

    k15_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (24)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (push_dat),
        .rsp_dat  (i_k15_rsp_dat),
        .rsp_req  (i_k15_rsp_req),
        .rsp_ack  (i_k15_rsp_ack),
        .count    (rsp_count),
        .full     (rsp_full)
    );

    // The CLR response relies on the buffer never growing during the sweep
    a_clr_no_growth: assert property (@(posedge clk) disable iff (!reset_n)
        (state == K15_CLR_RUN && !clr_done) |=> (rsp_count <= $past(rsp_count)));

endmodule

// File: tb/tb_k15_op_resp.sv
// Directed bench for k15_op_resp. Inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge. Expected responses are queued
// by the stimulus and compared in order as each one is handed downstream.
module tb_k15_op_resp;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] op_dat = '0;
    logic        op_req = 1'b0;
    logic        op_ack;
    logic [23:0] rsp_dat;
    logic        rsp_req;
    logic        rsp_ack = 1'b0;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [23:0] exp_q [$];

    always #5 clk = ~clk;

    k15_op_resp dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .t_k15_op_dat  (op_dat),
        .t_k15_op_req  (op_req),
        .t_k15_op_ack  (op_ack),
        .i_k15_rsp_dat (rsp_dat),
        .i_k15_rsp_req (rsp_req),
        .i_k15_rsp_ack (rsp_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response scoreboard: every handed-off response must match the queue head
    always @(negedge clk) begin
        if (reset_n && rsp_req && rsp_ack) begin
            if (exp_q.size() == 0)
                check("rsp_extra", 32'(exp_q.size()), 32'd1);
            else
                check("rsp", {8'h0, rsp_dat}, {8'h0, exp_q.pop_front()});
        end
    end

    // Caller has already presented req/dat at posedge+1; returns at posedge+1
    task automatic wait_accept();
        int k = 0;
        @(negedge clk);
        while (!op_ack && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!op_ack) check("op_ack_timeout", {31'b0, op_ack}, 32'd1);
        @(posedge clk);
        #1;
        op_req = 1'b0;
        op_dat = '0;
    endtask

    task automatic send(input logic [3:0] o, input logic [3:0] a, input logic [15:0] d);
        op_dat = {o, a, d};
        op_req = 1'b1;
        wait_accept();
    endtask

    task automatic expect_rsp(input logic [3:0] o, input logic [3:0] a, input logic [15:0] d);
        exp_q.push_back({o, a, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // ---- 1: reset values, WR then RD, first response latency ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_op_ack", {31'b0, op_ack}, 32'd0);
        check("rst_rsp_req", {31'b0, rsp_req}, 32'd0);
        check("rst_rsp_dat", {8'h0, rsp_dat}, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("ack_before_edge", {31'b0, op_ack}, 32'd0);
        @(negedge clk);
        check("ack_after_edge", {31'b0, op_ack}, 32'd1);
        @(posedge clk);
        #1 rsp_ack = 1'b1;

        expect_rsp(4'h1, 4'h3, 16'h1234);
        send(4'h1, 4'h3, 16'h1234);
        @(negedge clk);
        check("lat_req", {31'b0, rsp_req}, 32'd1);
        check("lat_dat", {8'h0, rsp_dat}, 32'h0013_1234);
        @(posedge clk);
        #1;
        expect_rsp(4'h2, 4'h3, 16'h1234);
        send(4'h2, 4'h3, 16'h0000);

        // ---- 2: ADD wraps, back-to-back ops see prior results ----
        expect_rsp(4'h1, 4'h5, 16'hFFFF);
        send(4'h1, 4'h5, 16'hFFFF);
        expect_rsp(4'h3, 4'h5, 16'h0001);
        send(4'h3, 4'h5, 16'h0002);
        expect_rsp(4'h2, 4'h5, 16'h0001);
        send(4'h2, 4'h5, 16'h0000);

        // ---- 3: downstream stall, buffer fills, order preserved ----
        repeat (3) @(posedge clk);
        #1 rsp_ack = 1'b0;
        expect_rsp(4'h1, 4'h6, 16'hAAAA);
        send(4'h1, 4'h6, 16'hAAAA);
        expect_rsp(4'h1, 4'h7, 16'h5555);
        send(4'h1, 4'h7, 16'h5555);
        expect_rsp(4'h2, 4'h6, 16'hAAAA);
        op_dat = {4'h2, 4'h6, 16'h0000};
        op_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_op_ack", {31'b0, op_ack}, 32'd0);
            check("stall_rsp_req", {31'b0, rsp_req}, 32'd1);
            check("stall_rsp_dat", {8'h0, rsp_dat}, 32'h0016_AAAA);
        end
        @(posedge clk);
        #1 rsp_ack = 1'b1;
        wait_accept();

        // ---- 4: CLR sweeps the register file with the op port closed ----
        for (int i = 0; i < 4; i++) begin
            expect_rsp(4'h1, 4'(8 + i), 16'h1000 + 16'(i));
            send(4'h1, 4'(8 + i), 16'h1000 + 16'(i));
        end
        expect_rsp(4'h4, 4'h0, 16'h0010);
        send(4'h4, 4'h0, 16'h0000);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (op_ack) break;
            cnt++;
        end
        check("clr_ack_low_cycles", 32'(cnt), 32'd16);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            expect_rsp(4'h2, 4'(8 + i), 16'h0000);
            send(4'h2, 4'(8 + i), 16'h0000);
        end
        expect_rsp(4'h2, 4'h3, 16'h0000);
        send(4'h2, 4'h3, 16'h0000);

        // ---- 5: unknown opcodes echo as errors, NOP is silent ----
        expect_rsp(4'h1, 4'h2, 16'h2222);
        send(4'h1, 4'h2, 16'h2222);
        expect_rsp(4'hF, 4'h2, 16'hBEEF);
        send(4'h7, 4'h2, 16'hBEEF);
        expect_rsp(4'h2, 4'h2, 16'h2222);
        send(4'h2, 4'h2, 16'h0000);
        expect_rsp(4'hF, 4'h9, 16'h0001);
        send(4'hF, 4'h9, 16'h0001);
        send(4'h0, 4'h4, 16'h5A5A);
        @(negedge clk);
        @(negedge clk);
        check("nop_no_rsp", {31'b0, rsp_req}, 32'd0);
        @(posedge clk);
        #1;
        expect_rsp(4'h2, 4'h4, 16'h0000);
        send(4'h2, 4'h4, 16'h0000);

        // ---- 6: reset in the middle of a CLR with a buffered response ----
        repeat (3) @(posedge clk);
        #1 rsp_ack = 1'b0;
        send(4'h1, 4'hC, 16'h0C0C);
        send(4'h4, 4'h0, 16'h0000);
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("midclr_rsp_req", {31'b0, rsp_req}, 32'd0);
        check("midclr_op_ack", {31'b0, op_ack}, 32'd0);
        check("midclr_rsp_dat", {8'h0, rsp_dat}, 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_rsp_req", {31'b0, rsp_req}, 32'd0);
        @(negedge clk);
        check("post_rst_op_ack", {31'b0, op_ack}, 32'd1);
        @(posedge clk);
        #1 rsp_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            expect_rsp(4'h2, 4'(i), 16'h0000);
            send(4'h2, 4'(i), 16'h0000);
        end
        repeat (4) @(negedge clk);
        check("rsp_drain", 32'(exp_q.size()), 32'd0);
        check("final_rsp_req", {31'b0, rsp_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
